// File: rtl/kws_inference_scheduler.sv
// Round-robin front end that shares one keyword-spotting inference core between NUM_REQ clients,
// with a watchdog that aborts and soft-resets a core that never reports valid.
module kws_inference_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 4,
  parameter int MAX_INDEX = 9,
  parameter int TO_W      = 20,
  parameter int TIMEOUT   = 500000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [3:0]               rsp_class,
  output logic [1:0]               rsp_err,
  output logic                     nn_start,
  output logic [IDX_W-1:0]         nn_sample_index,
  input  logic                     nn_valid,
  input  logic [3:0]               nn_class,
  output logic                     nn_srst_n,
  output logic                     busy,
  output logic [15:0]              done_cnt,
  output logic [7:0]               timeout_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, GRANT, RUN, DRAIN, RESP, ABORT} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   rr_q, gnt_q, pick;
  logic               hit;
  logic [IDX_W-1:0]   idx_q;
  logic [TO_W-1:0]    wd_q;
  logic [1:0]         ab_q;
  logic [NUM_REQ-1:0] req_ready_q, rsp_valid_q, gnt_oh;
  logic [3:0]         rsp_class_q;
  logic [1:0]         rsp_err_q;
  logic               nn_start_q, nn_srst_q;
  logic [15:0]        done_cnt_q;
  logic [7:0]         timeout_cnt_q;
  logic               wd_hit, idx_bad;
  int                 cand;

  // Scan from rr_q upward with wrap; iterating high-to-low lets the closest hit win.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = 0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_valid[cand]) begin
        hit  = 1'b1;
        pick = PTR_W'(cand);
      end
    end
  end

  assign gnt_oh  = NUM_REQ'(1) << gnt_q;
  assign wd_hit  = (wd_q >= TO_W'(TIMEOUT-1));
  assign idx_bad = (int'(idx_q) > MAX_INDEX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      gnt_q         <= '0;
      idx_q         <= '0;
      wd_q          <= '0;
      ab_q          <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_class_q   <= '0;
      rsp_err_q     <= '0;
      nn_start_q    <= 1'b0;
      nn_srst_q     <= 1'b1;
      done_cnt_q    <= '0;
      timeout_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            gnt_q       <= pick;
            idx_q       <= req_index[int'(pick)*IDX_W +: IDX_W];
            req_ready_q <= NUM_REQ'(1) << pick;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          req_ready_q <= '0;
          rr_q        <= (gnt_q == PTR_W'(NUM_REQ-1)) ? '0 : gnt_q + PTR_W'(1);
          if (idx_bad) begin
            rsp_err_q   <= 2'd2;
            rsp_class_q <= '0;
            rsp_valid_q <= gnt_oh;
            state_q     <= RESP;
          end else begin
            nn_start_q <= 1'b1;
            wd_q       <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          wd_q <= wd_q + TO_W'(1);
          if (nn_valid) begin
            rsp_class_q <= nn_class;
            nn_start_q  <= 1'b0;
            // Drain gets its own full watchdog budget, so a late-but-valid result is not aborted.
            wd_q        <= '0;
            state_q     <= DRAIN;
          end else if (wd_hit) begin
            nn_start_q <= 1'b0;
            nn_srst_q  <= 1'b0;
            ab_q       <= '0;
            state_q    <= ABORT;
          end
        end
        DRAIN: begin
          wd_q <= wd_q + TO_W'(1);
          if (!nn_valid) begin
            rsp_err_q   <= 2'd0;
            rsp_valid_q <= gnt_oh;
            state_q     <= RESP;
          end else if (wd_hit) begin
            nn_srst_q <= 1'b0;
            ab_q      <= '0;
            state_q   <= ABORT;
          end
        end
        ABORT: begin
          ab_q <= ab_q + 2'd1;
          if (ab_q == 2'd3) begin
            nn_srst_q   <= 1'b1;
            rsp_err_q   <= 2'd1;
            rsp_class_q <= '0;
            rsp_valid_q <= gnt_oh;
            if (timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 8'd1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (|(rsp_ready & gnt_oh)) begin
            if (rsp_err_q == 2'd0) done_cnt_q <= done_cnt_q + 16'd1;
            rsp_valid_q <= '0;
            rsp_class_q <= '0;
            rsp_err_q   <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_class       = rsp_class_q;
  assign rsp_err         = rsp_err_q;
  assign nn_start        = nn_start_q;
  assign nn_sample_index = idx_q;
  assign nn_srst_n       = nn_srst_q;
  assign busy            = (state_q != IDLE);
  assign done_cnt        = done_cnt_q;
  assign timeout_cnt     = timeout_cnt_q;

endmodule

// File: tb/tb_kws_inference_scheduler.sv
// Directed bench for kws_inference_scheduler with a small behavioural inference core model.
module tb_kws_inference_scheduler;
  localparam int NR = 4;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [NR*IW-1:0]  req_index = '0;
  logic [3:0]        rsp_class;
  logic [1:0]        rsp_err;
  logic              nn_start, nn_valid, nn_srst_n, busy;
  logic [IW-1:0]     nn_sample_index;
  logic [3:0]        nn_class;
  logic [15:0]       done_cnt;
  logic [7:0]        timeout_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kws_inference_scheduler #(.NUM_REQ(NR), .IDX_W(IW), .MAX_INDEX(9), .TO_W(20), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_class(rsp_class), .rsp_err(rsp_err),
    .nn_start(nn_start), .nn_sample_index(nn_sample_index), .nn_valid(nn_valid), .nn_class(nn_class),
    .nn_srst_n(nn_srst_n), .busy(busy), .done_cnt(done_cnt), .timeout_cnt(timeout_cnt)
  );

  // Core model: valid rises core_lat cycles after start, holds while start is high.
  int        core_lat = 50;
  bit        core_hang = 1'b0;
  bit        cls_from_idx = 1'b0;
  logic [3:0] core_cls = 4'd7;
  int        ccnt;
  logic      cvalid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt <= 0; cvalid <= 1'b0;
    end else if (!nn_srst_n) begin
      ccnt <= 0; cvalid <= 1'b0;
    end else if (nn_start) begin
      if (!cvalid && !core_hang) begin
        if (ccnt == core_lat-1) cvalid <= 1'b1;
        ccnt <= ccnt + 1;
      end
    end else begin
      ccnt <= 0; cvalid <= 1'b0;
    end
  end

  assign nn_valid = cvalid;
  assign nn_class = cls_from_idx ? nn_sample_index + 4'd2 : core_cls;

  int   start_hi = 0, start_rise = 0, srst_lo = 0;
  logic start_prev = 1'b0;
  always @(posedge clk) begin
    if (nn_start) start_hi <= start_hi + 1;
    if (nn_start && !start_prev) start_rise <= start_rise + 1;
    if (!nn_srst_n) srst_lo <= srst_lo + 1;
    start_prev <= nn_start;
  end

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '1;
    core_hang = 1'b0; cls_from_idx = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for a grant, withdraws that request, then waits for the response; gk=-1 on no grant.
  task automatic run_one(output int gk, output logic [NR-1:0] rv, output logic [3:0] cls, output logic [1:0] err);
    gk = -1; rv = '0; cls = '0; err = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int b = 0; b < NR; b++) if (req_ready[b]) gk = b;
        break;
      end
    end
    if (gk >= 0) req_valid[gk] = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        rv = rsp_valid; cls = rsp_class; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({req_ready, rsp_valid, rsp_class, rsp_err, nn_start, nn_sample_index, busy} !== '0) begin
      fails++; $display("FAIL reset_outs: got %0h want 0", {req_ready, rsp_valid, rsp_class, rsp_err, nn_start, nn_sample_index, busy});
    end
    tests++;
    if (nn_srst_n !== 1'b1) begin fails++; $display("FAIL reset_srst: got %b want 1", nn_srst_n); end
    tests++;
    if ({done_cnt, timeout_cnt} !== 24'h0) begin fails++; $display("FAIL reset_cnts: got %0h want 0", {done_cnt, timeout_cnt}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || nn_start !== 1'b0) begin fails++; $display("FAIL idle_after_reset: busy %b start %b want 0 0", busy, nn_start); end
  endtask

  task automatic test_basic();
    int sh0;
    sh0 = start_hi;
    core_lat = 50; core_cls = 4'd7;
    req_index[0 +: IW] = 4'd3; req_valid = 4'b0001;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL basic_accept: got %b want 0001", req_ready); end
    req_valid = '0;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL basic_ready_pulse: got %b want 0000", req_ready); end
    tests++;
    if (nn_start !== 1'b1 || nn_sample_index !== 4'd3) begin
      fails++; $display("FAIL basic_start: start %b idx %0d want 1 3", nn_start, nn_sample_index);
    end
    for (int c = 0; c < 1000; c++) begin
      if (rsp_valid != '0) break;
      @(negedge clk);
    end
    tests++;
    if (rsp_valid !== 4'b0001 || rsp_class !== 4'd7 || rsp_err !== 2'd0) begin
      fails++; $display("FAIL basic_rsp: rv %b cls %0d err %0d want 0001 7 0", rsp_valid, rsp_class, rsp_err);
    end
    tests++;
    if (start_hi - sh0 !== 51) begin fails++; $display("FAIL basic_start_cycles: got %0d want 51", start_hi - sh0); end
    @(negedge clk);
    tests++;
    if (done_cnt !== 16'd1 || busy !== 1'b0 || rsp_valid !== '0) begin
      fails++; $display("FAIL basic_done: cnt %0d busy %b rv %b want 1 0 0", done_cnt, busy, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int gk; logic [NR-1:0] rv; logic [3:0] cls; logic [1:0] err;
    do_reset();
    core_lat = 20; cls_from_idx = 1'b1;
    req_index = {4'd4, 4'd3, 4'd2, 4'd1};
    req_valid = 4'b1111;
    for (int k = 0; k < NR; k++) begin
      run_one(gk, rv, cls, err);
      tests++;
      if (gk !== k || rv !== (4'b0001 << k) || cls !== 4'(k + 3) || err !== 2'd0) begin
        fails++; $display("FAIL rr_order[%0d]: gk %0d rv %b cls %0d err %0d want %0d %b %0d 0", k, gk, rv, cls, err, k, 4'b0001 << k, k + 3);
      end
    end
    req_valid = 4'b0101;
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 0 || cls !== 4'd3) begin fails++; $display("FAIL rr_wrap_first: gk %0d cls %0d want 0 3", gk, cls); end
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 2 || cls !== 4'd5) begin fails++; $display("FAIL rr_wrap_second: gk %0d cls %0d want 2 5", gk, cls); end
    @(negedge clk);
    tests++;
    if (done_cnt !== 16'd6) begin fails++; $display("FAIL rr_done: got %0d want 6", done_cnt); end
  endtask

  task automatic test_timeout();
    int gk; int sh0; int sl0; logic [NR-1:0] rv; logic [3:0] cls; logic [1:0] err;
    do_reset();
    core_hang = 1'b1;
    sh0 = start_hi; sl0 = srst_lo;
    req_index[4 +: IW] = 4'd5; req_valid = 4'b0010;
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 1 || rv !== 4'b0010 || err !== 2'd1 || cls !== 4'd0) begin
      fails++; $display("FAIL to_rsp: gk %0d rv %b err %0d cls %0d want 1 0010 1 0", gk, rv, err, cls);
    end
    tests++;
    if (start_hi - sh0 !== 100) begin fails++; $display("FAIL to_cycles: got %0d want 100", start_hi - sh0); end
    tests++;
    if (srst_lo - sl0 !== 4) begin fails++; $display("FAIL to_srst_len: got %0d want 4", srst_lo - sl0); end
    tests++;
    if (timeout_cnt !== 8'd1) begin fails++; $display("FAIL to_cnt: got %0d want 1", timeout_cnt); end
    core_hang = 1'b0;
    // Valid arriving on the last watchdog cycle must win over the abort.
    core_lat = 99; core_cls = 4'd11;
    req_index[8 +: IW] = 4'd1; req_valid = 4'b0100;
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 2 || err !== 2'd0 || cls !== 4'd11 || timeout_cnt !== 8'd1) begin
      fails++; $display("FAIL to_coincide: gk %0d err %0d cls %0d tcnt %0d want 2 0 11 1", gk, err, cls, timeout_cnt);
    end
    @(negedge clk);
    tests++;
    if (done_cnt !== 16'd1) begin fails++; $display("FAIL to_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_bad_index();
    int gk; int sr0; logic [NR-1:0] rv; logic [3:0] cls; logic [1:0] err;
    do_reset();
    sr0 = start_rise;
    req_index[8 +: IW] = 4'd12; req_valid = 4'b0100;
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 2 || rv !== 4'b0100 || err !== 2'd2 || cls !== 4'd0) begin
      fails++; $display("FAIL badidx_rsp: gk %0d rv %b err %0d cls %0d want 2 0100 2 0", gk, rv, err, cls);
    end
    @(negedge clk);
    tests++;
    if (start_rise - sr0 !== 0 || done_cnt !== 16'd0) begin
      fails++; $display("FAIL badidx_nostart: rises %0d done %0d want 0 0", start_rise - sr0, done_cnt);
    end
    core_lat = 10; core_cls = 4'd4;
    req_index[4 +: IW] = 4'd9; req_valid = 4'b0010;
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 1 || err !== 2'd0 || cls !== 4'd4) begin
      fails++; $display("FAIL maxidx_ok: gk %0d err %0d cls %0d want 1 0 4", gk, err, cls);
    end
  endtask

  task automatic test_rsp_hold();
    int gk; bit stable; logic [NR-1:0] rv; logic [3:0] cls; logic [1:0] err;
    do_reset();
    rsp_ready = 4'b1101; core_lat = 10; core_cls = 4'd9;
    req_index[4 +: IW] = 4'd5; req_valid = 4'b0010;
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 1 || rv !== 4'b0010 || cls !== 4'd9) begin
      fails++; $display("FAIL hold_first: gk %0d rv %b cls %0d want 1 0010 9", gk, rv, cls);
    end
    req_index[12 +: IW] = 4'd2; req_valid = 4'b1000;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0010 || rsp_class !== 4'd9 || rsp_err !== 2'd0 || req_ready !== '0) stable = 1'b0;
    end
    tests++;
    if (stable !== 1'b1) begin fails++; $display("FAIL hold_stable: got %b want 1", stable); end
    rsp_ready = 4'b1111;
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 3 || rv !== 4'b1000 || cls !== 4'd9) begin
      fails++; $display("FAIL hold_next: gk %0d rv %b cls %0d want 3 1000 9", gk, rv, cls);
    end
    @(negedge clk);
    tests++;
    if (done_cnt !== 16'd2) begin fails++; $display("FAIL hold_done: got %0d want 2", done_cnt); end
  endtask

  task automatic test_async_reset();
    int gk; bit got; logic [NR-1:0] rv; logic [3:0] cls; logic [1:0] err;
    do_reset();
    core_lat = 50; core_cls = 4'd7;
    req_index[0 +: IW] = 4'd4; req_valid = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (req_ready[0]) req_valid = '0;
      if (nn_start) begin got = 1'b1; break; end
    end
    tests++;
    if (got !== 1'b1) begin fails++; $display("FAIL areset_start: got %b want 1", got); end
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (nn_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== '0) begin
      fails++; $display("FAIL areset_clear: start %b busy %b rv %b want 0 0 0", nn_start, busy, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_index[8 +: IW] = 4'd6; req_valid = 4'b0100;
    run_one(gk, rv, cls, err);
    tests++;
    if (gk !== 2 || rv !== 4'b0100 || cls !== 4'd7 || err !== 2'd0) begin
      fails++; $display("FAIL areset_fresh: gk %0d rv %b cls %0d err %0d want 2 0100 7 0", gk, rv, cls, err);
    end
    @(negedge clk);
    tests++;
    if (done_cnt !== 16'd1) begin fails++; $display("FAIL areset_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_bad_index();
    test_rsp_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
